adc_frame_sequencer: RTL

//  Downstream consumer of the 8-bit serial ADC driver. Runs the ADC's active-low startCapture/conversionComplete

---
 rtl/adc_frame_sequencer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: sequences one ADC startCapture/conversionComplete
// handshake per pixel over a COLS x ROWS frame, queues each sample in a
// first-word-fall-through FIFO and reports frame progress and completion.
// Optional feature macro: ADCSEQ_TIMEOUT_EN adds the TIMEOUT_CYC parameter,
// the timeout_err output and the REQ watchdog counter.
module adc_frame_sequencer #(
  parameter int DATA_W     = 8,
  parameter int COLS       = 112,
  parameter int ROWS       = 112,
  parameter int FIFO_DEPTH = 16
`ifdef ADCSEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          frame_abort,
  output logic                          startCapture,
  input  logic                          conversionComplete,
  input  logic [DATA_W-1:0]             adc_data,
  input  logic                          fifo_rd,
  output logic [DATA_W-1:0]             fifo_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(ROWS)-1:0]       row_idx,
  output logic [$clog2(COLS)-1:0]       col_idx
`ifdef ADCSEQ_TIMEOUT_EN
  , output logic                        timeout_err
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);

  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Sequencer state
  logic [2:0]        state_q, state_d;
  logic              sc_q, sc_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CLW-1:0]    col_q, col_d;
  logic              last_q, last_d;   // sample just written was the frame's last
  logic              push;

  // FIFO state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              empty_q, full_q;
  logic              pop;

`ifdef ADCSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          terr_q, terr_d;
  assign timeout_err = terr_q;
`endif

  assign startCapture = sc_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign row_idx      = row_q;
  assign col_idx      = col_q;
  assign fifo_data    = data_q;
  assign fifo_empty   = empty_q;
  assign fifo_full    = full_q;
  assign fifo_count   = count_q;

  // Handshake FSM next-state; abort always wins over a same-cycle ADC edge
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    push    = 1'b0;
`ifdef ADCSEQ_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        sc_d = 1'b1;
        if (frame_start) begin
          row_d   = '0;
          col_d   = '0;
          last_d  = 1'b0;
          state_d = S_CHECK;
`ifdef ADCSEQ_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      S_CHECK: begin
        if (frame_abort) begin
          state_d = S_IDLE;
        end else if (!full_q) begin
          sc_d    = 1'b0;
          state_d = S_REQ;
`ifdef ADCSEQ_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      S_REQ: begin
        if (frame_abort) begin
          sc_d    = 1'b1;
          state_d = S_DRAIN;
        end else if (!conversionComplete) begin
          // CHECK guaranteed a free slot, so this write never overflows
          push   = 1'b1;
          last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          sc_d    = 1'b1;
          state_d = S_ACK;
        end
`ifdef ADCSEQ_TIMEOUT_EN
        else if (tcnt_q == T_LAST) begin
          terr_d  = 1'b1;
          sc_d    = 1'b1;
          state_d = S_DRAIN;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      S_ACK: begin
        if (frame_abort) begin
          state_d = S_DRAIN;
        end else if (conversionComplete) begin
          if (last_q) begin
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_DRAIN: begin
        sc_d = 1'b1;
        if (conversionComplete) state_d = S_IDLE;
      end
      default: begin
        sc_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sc_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
`ifdef ADCSEQ_TIMEOUT_EN
      tcnt_q  <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
`ifdef ADCSEQ_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  // FIFO next-state; the registered head is mem[rd_ptr] after this cycle's write
  always_comb begin
    pop      = fifo_rd && !empty_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && (wr_ptr_q == rd_ptr_d)) data_d = adc_data;
    else                                data_d = mem_q[rd_ptr_d];
  end

  // FIFO storage, pointers and flags; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= adc_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_FULL);
    end
  end

endmodule
